enc_16by4_al_seq: RTL and testbench
===================================

ENC_16BY4_AL_SEQ -- requirements
Module: enc_16by4_al_seq

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows:
  clk    input   1   rising-edge clock
  rst_n  input   1   asynchronous active-low reset
  a      input   16  request lines, active-low (a[i]=0 means request i)
  e      input   1   capture enable, active-low (e=0 captures requests)
  ack    input   1   consumer acknowledge, active-high
  Y      output  4   binary index of the granted request
  valid  output  1   Y holds a grant, active-high
  pend   output  16  sticky pending-request register, active-high per index
REQ-003 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Function
REQ-004 Capture: on each rising edge with e=0, the block SHALL update pend[i] <= pend[i] | ~a[i] for all i.
REQ-005 With e=1, no new request SHALL be captured, and existing pend bits SHALL be held except when cleared per REQ-009.
REQ-006 The FSM SHALL have two states, IDLE and GRANT, and SHALL reset to IDLE.
REQ-007 IDLE behaviour:
  - If the registered pend is nonzero, the block SHALL set Y to the highest set index and valid to 1 on the next edge, then enter GRANT.
  - Otherwise it SHALL remain in IDLE with valid=0.
REQ-008 GRANT behaviour:
  - Y and valid SHALL hold stable until ack=1 is sampled.
  - A newly captured higher-priority request SHALL NOT preempt the current grant.
REQ-009 When ack=1 is sampled in GRANT:
  - pend[Y] SHALL clear.
  - valid SHALL drop to 0.
  - The FSM SHALL return to IDLE.
  - Y SHALL retain its last value.
REQ-010 Set overrides clear: if e=0 and a[Y]=0 in the ack cycle, pend[Y] SHALL remain 1.
REQ-011 ack SHALL be ignored in IDLE and SHALL NOT alter pend.
REQ-012 After each ack, valid SHALL be 0 for at least one cycle before the next grant.
REQ-013 Latency: a request applied (a[i]=0, e=0) before edge k SHALL set pend[i] at edge k and SHALL produce valid=1 with Y=i at edge k+1, provided the FSM is in IDLE and i is the highest pending index.
REQ-014 Back-to-back throughput: with ack held at 1, the block SHALL issue one grant every 2 cycles, in descending index order.
REQ-015 Requests SHALL be level-captured: a request held low across several edges SHALL produce exactly one pend set, and SHALL re-set pend after an ack only if it is still low with e=0.

Reset
REQ-016 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, force:
  - valid=0
  - Y=4'b0000
  - pend=16'h0000
  - FSM to IDLE
REQ-017 A reset asserted mid-grant SHALL discard the grant and all pending requests, with no ack required.
REQ-018 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover single request:
  - Stimulus: a=16'hFFFB (request 2), e=0 for one cycle, then a=16'hFFFF.
  - Response: pend=16'h0004 after edge k; Y=2 and valid=1 after edge k+1; after ack, pend=0 and valid=0.
REQ-020 The bench SHALL cover priority order:
  - Stimulus: a=16'h7FFE (requests 15 and 0) captured together, ack held at 1.
  - Response: grants Y=15, then Y=0, two cycles apart; then pend=0.
REQ-021 The bench SHALL cover no preemption:
  - Stimulus: while a grant for Y=3 is pending without ack, request 12 is captured.
  - Response: Y stays 3 until ack; then Y=12 is granted.
REQ-022 The bench SHALL cover enable gating:
  - Stimulus: a=16'h0000 with e=1 for 5 cycles.
  - Response: pend stays 0 and valid stays 0.
  - Stimulus: drop e to 0.
  - Response: pend=16'hFFFF.
REQ-023 The bench SHALL cover set-over-clear:
  - Stimulus: a[5] held low with e=0 through the ack of Y=5.
  - Response: pend[5] stays 1; valid=0 for one cycle; then Y=5 and valid=1 again.
REQ-024 The bench SHALL cover asynchronous reset mid-grant:
  - Stimulus: rst_n pulsed low between edges while valid=1 and pend=16'h0110.
  - Response: valid=0, Y=0, pend=0 immediately; no grant follows until a new request.

Source files
------------

// File: rtl/enc_16by4_al_seq.sv
// Sticky 16-request priority encoder: captures active-low requests into pend,
// grants the highest pending index and holds it until acked. All outputs come from flops.
module enc_16by4_al_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        e,
  input  logic        ack,
  output logic [3:0]  Y,
  output logic        valid,
  output logic [15:0] pend
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  y_q, y_d;
  logic        valid_q, valid_d;
  logic [3:0]  top_idx;

  // Ascending scan so the highest set index is the last assignment to stick.
  always_comb begin
    top_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pend_q[i]) top_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    y_d     = y_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pend_q != 16'h0000) begin
          y_d     = top_idx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          pend_d[y_q] = 1'b0;
          valid_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture is applied after the ack clear so a live request wins.
    if (!e) pend_d = pend_d | ~a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 16'h0000;
      y_q     <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_enc_16by4_al_seq.sv
// Bench for enc_16by4_al_seq: directed scenarios with fixed expectations, then random
// traffic against a cycle-level behavioural model of the request/grant protocol.
module tb_enc_16by4_al_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic        e;
  logic        ack;
  logic [3:0]  Y;
  logic        valid;
  logic [15:0] pend;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit [15:0] m_pend;
  bit        m_busy;
  int        m_y;

  enc_16by4_al_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .e     (e),
    .ack   (ack),
    .Y     (Y),
    .valid (valid),
    .pend  (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int highest(input bit [15:0] p);
    for (int i = 15; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_busy = 1'b0;
    m_y    = 0;
  endtask

  // One clock edge of the protocol, computed from the pre-edge state.
  task automatic model_edge(input bit [15:0] ai, input bit ei, input bit acki);
    bit [15:0] np;
    np = m_pend;
    if (m_busy && acki) begin
      np[m_y] = 1'b0;
      m_busy  = 1'b0;
    end else if (!m_busy && m_pend != 0) begin
      m_y    = highest(m_pend);
      m_busy = 1'b1;
    end
    if (!ei) np = np | ~ai;
    m_pend = np;
  endtask

  task automatic model_chk(input string tag);
    chk({tag, ".pend"},  {16'h0, pend},  {16'h0, m_pend});
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, m_busy});
    chk({tag, ".Y"},     {28'h0, Y},     32'(m_y));
  endtask

  // Drive inputs, take one edge, then compare on the falling edge.
  task automatic step(input logic [15:0] ai, input logic ei, input logic acki, input string tag);
    a = ai; e = ei; ack = acki;
    @(posedge clk);
    model_edge(ai, ei, acki);
    @(negedge clk);
    model_chk(tag);
  endtask

  task automatic do_reset();
    a = 16'hFFFF; e = 1'b1; ack = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.valid", {31'h0, valid}, 32'h0);
    chk("rst.Y",     {28'h0, Y},     32'h0);
    chk("rst.pend",  {16'h0, pend},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single request 2
    step(16'hFFFB, 1'b0, 1'b0, "single.cap");
    chk("single.pend", {16'h0, pend}, 32'h0004);
    step(16'hFFFF, 1'b1, 1'b0, "single.grant");
    chk("single.Y", {28'h0, Y}, 32'd2);
    chk("single.valid", {31'h0, valid}, 32'h1);
    step(16'hFFFF, 1'b1, 1'b1, "single.ack");
    chk("single.pend0", {16'h0, pend}, 32'h0);
    chk("single.valid0", {31'h0, valid}, 32'h0);
    chk("single.Yhold", {28'h0, Y}, 32'd2);
    step(16'hFFFF, 1'b1, 1'b1, "single.idle_ack");

    // Priority with ack held high
    step(16'h7FFE, 1'b0, 1'b1, "prio.cap");
    chk("prio.pend", {16'h0, pend}, 32'h8001);
    step(16'hFFFF, 1'b1, 1'b1, "prio.g15");
    chk("prio.Y15", {28'h0, Y}, 32'd15);
    step(16'hFFFF, 1'b1, 1'b1, "prio.gap");
    chk("prio.gap_valid", {31'h0, valid}, 32'h0);
    step(16'hFFFF, 1'b1, 1'b1, "prio.g0");
    chk("prio.Y0", {28'h0, Y}, 32'd0);
    chk("prio.valid0", {31'h0, valid}, 32'h1);
    step(16'hFFFF, 1'b1, 1'b1, "prio.done");
    chk("prio.pend0", {16'h0, pend}, 32'h0);

    // No preemption
    step(16'hFFF7, 1'b0, 1'b0, "nopre.cap3");
    step(16'hFFFF, 1'b1, 1'b0, "nopre.g3");
    step(16'hEFFF, 1'b0, 1'b0, "nopre.cap12");
    chk("nopre.Y3a", {28'h0, Y}, 32'd3);
    step(16'hFFFF, 1'b1, 1'b0, "nopre.hold");
    chk("nopre.Y3b", {28'h0, Y}, 32'd3);
    step(16'hFFFF, 1'b1, 1'b1, "nopre.ack3");
    chk("nopre.pend", {16'h0, pend}, 32'h1000);
    step(16'hFFFF, 1'b1, 1'b0, "nopre.g12");
    chk("nopre.Y12", {28'h0, Y}, 32'd12);
    step(16'hFFFF, 1'b1, 1'b1, "nopre.ack12");

    // Enable gating
    for (int i = 0; i < 5; i++) begin
      step(16'h0000, 1'b1, 1'b0, "gate.off");
      chk("gate.pend0", {16'h0, pend}, 32'h0);
      chk("gate.valid0", {31'h0, valid}, 32'h0);
    end
    step(16'h0000, 1'b0, 1'b0, "gate.on");
    chk("gate.pendF", {16'h0, pend}, 32'hFFFF);
    do_reset();

    // Set overrides clear on request 5
    step(16'hFFDF, 1'b0, 1'b0, "soc.cap");
    step(16'hFFDF, 1'b0, 1'b0, "soc.g5");
    chk("soc.Y5", {28'h0, Y}, 32'd5);
    step(16'hFFDF, 1'b0, 1'b1, "soc.ack");
    chk("soc.pend5", {16'h0, pend}, 32'h0020);
    chk("soc.gap", {31'h0, valid}, 32'h0);
    step(16'hFFFF, 1'b1, 1'b0, "soc.regrant");
    chk("soc.Y5b", {28'h0, Y}, 32'd5);
    chk("soc.valid", {31'h0, valid}, 32'h1);
    step(16'hFFFF, 1'b1, 1'b1, "soc.ack2");

    // Asynchronous reset mid-grant
    step(16'hFEEF, 1'b0, 1'b0, "arst.cap");
    chk("arst.pend", {16'h0, pend}, 32'h0110);
    step(16'hFFFF, 1'b1, 1'b0, "arst.g8");
    chk("arst.valid1", {31'h0, valid}, 32'h1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.valid", {31'h0, valid}, 32'h0);
    chk("arst.Y",     {28'h0, Y},     32'h0);
    chk("arst.pend",  {16'h0, pend},  32'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'hFFFF, 1'b1, 1'b1, "arst.quiet");
      chk("arst.noval", {31'h0, valid}, 32'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra;
      ra = 16'($urandom) | 16'($urandom) | 16'($urandom);
      step(ra, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
